// File: rtl/spike_rate_decoder.sv
// Spike-train readout: per-channel spike counts over a programmable window plus
// the most recent inter-spike interval, delivered as one snapshot per window.
module spike_rate_decoder #(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned WIN_BITS  = 8,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned ISI_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [N_CH-1:0]               spike_in,
    input  logic [WIN_BITS-1:0]           window_len,
    output logic [N_CH*CNT_WIDTH-1:0]     rate_out,
    output logic [N_CH*ISI_WIDTH-1:0]     isi_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overrun
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [ISI_WIDTH-1:0] ISI_MAX = '1;

    typedef enum logic {IDLE, COUNT} state_t;

    state_t                state, next_state;
    logic [WIN_BITS-1:0]   wcnt, win_q, cur_last;
    logic [N_CH-1:0]       spike_prev, seen, ev;
    logic [CNT_WIDTH-1:0]  cnt      [N_CH];
    logic [CNT_WIDTH-1:0]  cnt_next [N_CH];
    logic [ISI_WIDTH-1:0]  timer      [N_CH];
    logic [ISI_WIDTH-1:0]  timer_next [N_CH];
    logic [ISI_WIDTH-1:0]  isi_last [N_CH];
    logic [ISI_WIDTH-1:0]  isi_next [N_CH];
    logic                  win_close, accept, xfer;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state and next datapath values; the entry edge already uses the live window_len
    always_comb begin
        next_state = IDLE;
        cur_last   = win_q;
        ev         = '0;
        win_close  = 1'b0;
        accept     = 1'b0;
        xfer       = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            cnt_next[c]   = cnt[c];
            timer_next[c] = timer[c];
            isi_next[c]   = isi_last[c];
        end

        if (enable) next_state = COUNT;
        if (state == IDLE) cur_last = window_len;
        ev        = spike_in & ~spike_prev;
        win_close = enable && (wcnt == cur_last);
        accept    = !out_valid || out_ready;
        xfer      = out_valid && out_ready;

        for (int c = 0; c < N_CH; c++) begin
            if (ev[c] && (cnt[c] != CNT_MAX)) cnt_next[c] = cnt[c] + CNT_WIDTH'(1);
            if (ev[c])                        timer_next[c] = ISI_WIDTH'(1);
            else if (timer[c] != ISI_MAX)     timer_next[c] = timer[c] + ISI_WIDTH'(1);
            if (ev[c] && seen[c])             isi_next[c] = timer[c];
        end
    end

    // Counting datapath and registered snapshot outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt       <= '0;
            win_q      <= '0;
            spike_prev <= '0;
            seen       <= '0;
            rate_out   <= '0;
            isi_out    <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                cnt[c]      <= '0;
                timer[c]    <= '0;
                isi_last[c] <= '0;
            end
        end else begin
            if (!enable) begin
                wcnt       <= '0;
                win_q      <= '0;
                spike_prev <= '0;
                seen       <= '0;
                for (int c = 0; c < N_CH; c++) begin
                    cnt[c]      <= '0;
                    timer[c]    <= '0;
                    isi_last[c] <= '0;
                end
            end else begin
                spike_prev <= spike_in;
                seen       <= seen | ev;
                if (state == IDLE) win_q <= window_len;
                for (int c = 0; c < N_CH; c++) begin
                    timer[c]    <= timer_next[c];
                    isi_last[c] <= isi_next[c];
                end
                if (win_close) begin
                    wcnt  <= '0;
                    win_q <= window_len;
                    for (int c = 0; c < N_CH; c++) cnt[c] <= '0;
                end else begin
                    wcnt <= wcnt + WIN_BITS'(1);
                    for (int c = 0; c < N_CH; c++) cnt[c] <= cnt_next[c];
                end
            end

            // A pending, unaccepted snapshot wins over a newly closed window
            if (win_close && accept) begin
                out_valid <= 1'b1;
                for (int c = 0; c < N_CH; c++) begin
                    rate_out[c*CNT_WIDTH +: CNT_WIDTH] <= cnt_next[c];
                    isi_out[c*ISI_WIDTH +: ISI_WIDTH]  <= isi_next[c];
                end
            end else if (win_close) begin
                overrun <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
